// File: rtl/pipe_drain_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_drain_buffer_pkg : shared width helper and depth check constant  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package pipe_drain_buffer_pkg;

   localparam int c_default_depth = 8;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

   localparam bit c_default_depth_ok = is_pow2(c_default_depth);

endpackage
`default_nettype wire

// File: rtl/pipe_drain_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_drain_buffer_if : issue credit, pipeline return and output bus   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface pipe_drain_buffer_if #(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_DEPTH      = 8
);
   import pipe_drain_buffer_pkg::*;

   localparam int c_cnt_w = clog2(C_DEPTH) + 1;

   logic                    issue_req;
   logic                    issue_ok;
   logic                    in_valid;
   logic [C_DATA_WIDTH-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [C_DATA_WIDTH-1:0] out_data;
   logic [c_cnt_w-1:0]      occupancy;
   logic [c_cnt_w-1:0]      inflight;

   modport master (
      output issue_req, in_valid, in_data, out_ready,
      input  issue_ok, out_valid, out_data, occupancy, inflight
   );

   modport slave (
      input  issue_req, in_valid, in_data, out_ready,
      output issue_ok, out_valid, out_data, occupancy, inflight
   );

endinterface
`default_nettype wire

// File: rtl/pipe_drain_buffer_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdb_ram : dual-port RAM, synchronous write, asynchronous read         |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module pdb_ram
   import pipe_drain_buffer_pkg::*;
#(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_DEPTH      = 8
) (
   input  wire logic                        clk,
   input  wire logic                        i_we,
   input  wire logic [clog2(C_DEPTH)-1:0]   i_waddr,
   input  wire logic [C_DATA_WIDTH-1:0]     i_wdata,
   input  wire logic [clog2(C_DEPTH)-1:0]   i_raddr,
   output      logic [C_DATA_WIDTH-1:0]     o_rdata
);

   logic [C_DATA_WIDTH-1:0] r_mem [C_DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pipe_drain_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_drain_buffer : credit-gated FWFT buffer behind a fixed pipeline  |
// | Optional macro PIPE_DRAIN_BUFFER_ERR_EN adds sticky protocol err.     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module pipe_drain_buffer
   import pipe_drain_buffer_pkg::*;
#(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_LATENCY    = 4,
   parameter int C_DEPTH      = 8
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
`ifdef PIPE_DRAIN_BUFFER_ERR_EN
   output      logic              err,
`endif
   pipe_drain_buffer_if.slave     bus
);

   localparam int              c_aw   = clog2(C_DEPTH);
   localparam int              c_cw   = c_aw + 1;
   localparam logic [c_cw-1:0] c_full = c_cw'(C_DEPTH);

   generate
      if (!is_pow2(C_DEPTH)) begin : g_bad_depth
         $error("pipe_drain_buffer: C_DEPTH must be a power of two >= 2");
      end
      if (C_LATENCY < 0) begin : g_bad_latency
         $error("pipe_drain_buffer: C_LATENCY must be >= 0");
      end
   endgenerate

   logic [c_aw-1:0]         r_wr_ptr;
   logic [c_aw-1:0]         r_rd_ptr;
   logic [c_cw-1:0]         r_occ;
   logic [c_cw-1:0]         r_infl;
   logic [C_DATA_WIDTH-1:0] r_out_data;
   logic [C_DATA_WIDTH-1:0] w_next_head;

   logic w_fire, w_pop, w_overflow, w_underrun, w_push, w_ret, w_head_from_in;

   assign w_fire     = bus.issue_req & bus.issue_ok;
   assign w_pop      = bus.out_valid & bus.out_ready;
   assign w_overflow = bus.in_valid & (r_occ == c_full) & ~w_pop;
   assign w_underrun = bus.in_valid & (r_infl == '0);
   assign w_push     = bus.in_valid & ~w_overflow;
   assign w_ret      = bus.in_valid & ~w_overflow & ~w_underrun;

   // The incoming word becomes the head when nothing older survives this cycle.
   assign w_head_from_in = w_push & ((r_occ == '0) | (w_pop & (r_occ == c_cw'(1))));

   pdb_ram #(
      .C_DATA_WIDTH (C_DATA_WIDTH),
      .C_DEPTH      (C_DEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.in_data),
      .i_raddr (r_rd_ptr + c_aw'(1)),
      .o_rdata (w_next_head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
         r_infl     <= '0;
         r_out_data <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);

         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + c_cw'(1);
            2'b01:   r_occ <= r_occ - c_cw'(1);
            default: r_occ <= r_occ;
         endcase

         case ({w_fire, w_ret})
            2'b10:   r_infl <= r_infl + c_cw'(1);
            2'b01:   r_infl <= r_infl - c_cw'(1);
            default: r_infl <= r_infl;
         endcase

         // Registered head keeps its last value once the buffer drains.
         if (w_head_from_in)
            r_out_data <= bus.in_data;
         else if (w_pop && (r_occ > c_cw'(1)))
            r_out_data <= w_next_head;
      end
   end

   assign bus.issue_ok  = ({1'b0, r_occ} + {1'b0, r_infl}) < {1'b0, c_full};
   assign bus.out_valid = (r_occ != '0);
   assign bus.out_data  = r_out_data;
   assign bus.occupancy = r_occ;
   assign bus.inflight  = r_infl;

`ifdef PIPE_DRAIN_BUFFER_ERR_EN
   logic r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else        r_err <= r_err | w_overflow | w_underrun;
   end

   assign err = r_err;
`endif

endmodule
`default_nettype wire
